// File: rtl/inst_encoder_if.sv
// Field-beat input channel and instruction-memory write channel of the
// instruction assembler. The slave modport is the encoder's view; the
// master modport is the loader/memory side that drives beats and acks writes.
interface inst_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
           in_imm, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
           in_imm, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction assembler: range-checks decoded field beats, packs them
// into instruction words and writes them sequentially into instruction memory.
module inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  inst_encoder_if.slave       bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [7:0]          err_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              wr_done;
  logic              enc_ok;
  logic [31:0]       enc_word;
  logic              imm12_ok;
  logic              imm13_ok;
  logic [ADDR_W-1:0] addr_cnt;

  assign bus.in_ready = (state == RUN) && (!bus.mem_we || bus.mem_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign wr_done      = bus.mem_we && bus.mem_ready;

  // Load state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (accept && bus.in_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (wr_done) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Immediate range checks and instruction packing; rejected beats become NOP.
  always_comb begin
    imm12_ok = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
    imm13_ok = (&bus.in_imm[31:12]) || !(|bus.in_imm[31:12]);
    enc_ok   = 1'b0;
    enc_word = NOP;
    case (bus.in_opcode)
      7'b0000011: begin
        enc_ok   = imm12_ok;
        enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                    bus.in_opcode};
      end
      7'b0010011: begin
        if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101) begin
          enc_ok   = !(|bus.in_imm[31:5]);
          enc_word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3,
                      bus.in_rd, bus.in_opcode};
        end else begin
          enc_ok   = imm12_ok;
          enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                      bus.in_opcode};
        end
      end
      7'b0100011: begin
        enc_ok   = imm12_ok;
        enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:0], bus.in_opcode};
      end
      7'b1100011: begin
        enc_ok   = imm13_ok && !bus.in_imm[0];
        enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                    bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
      end
      7'b0110011: begin
        enc_ok   = 1'b1;
        enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_rd, bus.in_opcode};
      end
      default: begin
        enc_ok   = 1'b0;
        enc_word = NOP;
      end
    endcase
    if (!enc_ok) enc_word = NOP;
  end

  // Memory write register: a new beat loads the write, completion retires it.
  // The address counter advances when a beat is registered rather than when
  // its write completes; every registered write completes before the next
  // address is consumed, so the address sequence is identical.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      addr_cnt      <= ADDR_W'(BASE_ADDR);
    end else begin
      if (state == IDLE && start) addr_cnt <= ADDR_W'(BASE_ADDR);
      if (accept) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= addr_cnt;
        bus.mem_wdata <= enc_word;
        addr_cnt      <= addr_cnt + ADDR_W'(1);
      end else if (wr_done) begin
        bus.mem_we <= 1'b0;
      end
    end
  end

  // Sticky error flag and saturating reject counter, cleared by start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (state == IDLE && start) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (accept && !enc_ok) begin
      err <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: two instances (8-bit/base 0 and
// 2-bit/base 3) receive identical stimulus; a scoreboard per instance is
// fed by the stimulus side and drained by a monitor on completed writes.
module tb_inst_encoder;

  localparam int AW_A = 8, BASE_A = 0;
  localparam int AW_B = 2, BASE_B = 3;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    int unsigned idx;
    int unsigned errc;
    logic        last;
  } item_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, mem_ready = 1'b0;
  logic [6:0] in_opcode = '0, in_funct7 = '0;
  logic [2:0] in_funct3 = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic rand_rdy = 1'b0;

  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [7:0] errc_a, errc_b;

  inst_encoder_if #(.ADDR_W(AW_A)) bus_a ();
  inst_encoder_if #(.ADDR_W(AW_B)) bus_b ();

  assign bus_a.in_valid = in_valid;   assign bus_b.in_valid = in_valid;
  assign bus_a.in_opcode = in_opcode; assign bus_b.in_opcode = in_opcode;
  assign bus_a.in_funct3 = in_funct3; assign bus_b.in_funct3 = in_funct3;
  assign bus_a.in_funct7 = in_funct7; assign bus_b.in_funct7 = in_funct7;
  assign bus_a.in_rd = in_rd;         assign bus_b.in_rd = in_rd;
  assign bus_a.in_rs1 = in_rs1;       assign bus_b.in_rs1 = in_rs1;
  assign bus_a.in_rs2 = in_rs2;       assign bus_b.in_rs2 = in_rs2;
  assign bus_a.in_imm = in_imm;       assign bus_b.in_imm = in_imm;
  assign bus_a.in_last = in_last;     assign bus_b.in_last = in_last;
  assign bus_a.mem_ready = mem_ready; assign bus_b.mem_ready = mem_ready;

  inst_encoder #(.ADDR_W(AW_A), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_a),
    .busy(busy_a), .done(done_a), .err(err_a), .err_count(errc_a));

  inst_encoder #(.ADDR_W(AW_B), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_count(errc_b));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  item_t qa[$], qb[$];
  int unsigned m_idx = 0, m_errc = 0;
  int exp_done = 0;
  int done_cnt [2] = '{0, 0};
  logic done_pend [2] = '{1'b0, 1'b0};
  logic prev_stall [2] = '{1'b0, 1'b0};
  logic [31:0] prev_addr [2], prev_data [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference encoder: immediate ranges checked as signed integers, fields
  // placed with shifts and masks.
  function automatic logic [32:0] ref_encode(input beat_t b);
    int v;
    logic ok;
    logic [31:0] w, op, f3, f7, rd, rs1, rs2;
    v = int'($signed(b.imm));
    op = 32'(b.op); f3 = 32'(b.f3); f7 = 32'(b.f7);
    rd = 32'(b.rd); rs1 = 32'(b.rs1); rs2 = 32'(b.rs2);
    ok = 1'b0;
    w  = 32'h13;
    if (b.op == 7'h03 || (b.op == 7'h13 && b.f3 != 3'd1 && b.f3 != 3'd5)) begin
      ok = (v >= -2048) && (v <= 2047);
      w  = ((b.imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    end else if (b.op == 7'h13) begin
      ok = (b.imm < 32'd32);
      w  = (f7 << 25) | ((b.imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    end else if (b.op == 7'h23) begin
      ok = (v >= -2048) && (v <= 2047);
      w  = (((b.imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
         | ((b.imm & 32'h1F) << 7) | op;
    end else if (b.op == 7'h63) begin
      ok = (v % 2 == 0) && (v >= -4096) && (v <= 4095);
      w  = (((b.imm >> 12) & 32'h1) << 31) | (((b.imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
         | (rs1 << 15) | (f3 << 12) | (((b.imm >> 1) & 32'hF) << 8)
         | (((b.imm >> 11) & 32'h1) << 7) | op;
    end else if (b.op == 7'h33) begin
      ok = 1'b1;
      w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    end
    return {ok, ok ? w : 32'h13};
  endfunction

  function automatic beat_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm);
    beat_t b;
    b.op = op; b.f3 = f3; b.f7 = f7; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    logic [31:0] edges [13];
    edges = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd4094, 32'd4096,
              32'hFFFF_F000, 32'hFFFF_EFFE, 32'd31, 32'd32, 32'd0, 32'd1, 32'd3};
    b.f3 = 3'($urandom_range(0, 7)); b.f7 = 7'($urandom_range(0, 127));
    b.rd = 5'($urandom_range(0, 31)); b.rs1 = 5'($urandom_range(0, 31));
    b.rs2 = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 6))
      0: b.op = 7'h03;
      1: b.op = 7'h13;
      2: b.op = 7'h23;
      3: b.op = 7'h63;
      4: b.op = 7'h33;
      5: begin b.op = 7'h13; b.f3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5; end
      default: b.op = 7'($urandom_range(0, 127));
    endcase
    case ($urandom_range(0, 4))
      0: b.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: b.imm = edges[$urandom_range(0, 12)];
      2: b.imm = 32'($urandom);
      3: b.imm = 32'($urandom_range(0, 63));
      default: b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
    endcase
    return b;
  endfunction

  // Presents one beat (called just after a rising edge), waits for acceptance
  // and pushes the expected write into both scoreboards.
  task automatic send_beat(input beat_t b, input logic last, input logic use_gold,
                           input logic [31:0] gold, output int stalls);
    logic [32:0] r;
    item_t it;
    stalls = 0;
    in_valid = 1'b1; in_opcode = b.op; in_funct3 = b.f3; in_funct7 = b.f7;
    in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2; in_imm = b.imm; in_last = last;
    @(negedge clk);
    while (!bus_a.in_ready && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    if (!bus_a.in_ready) begin
      timeout_fail("beat_accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    r = ref_encode(b);
    if (!r[32] && m_errc < 255) m_errc++;
    it.data = use_gold ? gold : r[31:0];
    it.idx  = m_idx;
    it.errc = m_errc;
    it.last = last;
    qa.push_back(it);
    qb.push_back(it);
    m_idx++;
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_idx  = 0;
    m_errc = 0;
  endtask

  task automatic end_program();
    int b;
    b = 0;
    while (busy_a && b < 1000) begin
      @(negedge clk);
      b++;
    end
    if (busy_a) timeout_fail("program_end");
    repeat (2) @(negedge clk);
    exp_done++;
    check("done_count_a", 32'(done_cnt[0]), 32'(exp_done));
    check("done_count_b", 32'(done_cnt[1]), 32'(exp_done));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus_a.in_ready | bus_b.in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(bus_a.mem_we | bus_b.mem_we), 32'd0);
    check({tag, "_mem_addr_a"}, 32'(bus_a.mem_addr), 32'd0);
    check({tag, "_mem_addr_b"}, 32'(bus_b.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, bus_a.mem_wdata | bus_b.mem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy_a | busy_b), 32'd0);
    check({tag, "_done"}, 32'(done_a | done_b), 32'd0);
    check({tag, "_err"}, 32'(err_a | err_b), 32'd0);
    check({tag, "_err_count"}, 32'(errc_a | errc_b), 32'd0);
  endtask

  // Monitor for one instance: write-hold stability, done timing, scoreboard.
  task automatic mon_step(input int k, input logic we, input logic rdy, input logic [31:0] addr,
                          input logic [31:0] data, input logic e, input logic [7:0] ec,
                          input logic dn, input logic bz, input logic ir);
    item_t it;
    logic have, exp_d;
    int unsigned exp_addr;
    string s;
    s = (k == 0) ? "a" : "b";
    if (!rst_n) begin
      if (k == 0) qa.delete(); else qb.delete();
      done_pend[k] = 1'b0;
      prev_stall[k] = 1'b0;
      return;
    end
    if (prev_stall[k]) begin
      check({"hold_we_", s}, 32'(we), 32'd1);
      check({"hold_addr_", s}, addr, prev_addr[k]);
      check({"hold_data_", s}, data, prev_data[k]);
    end
    if (we && !rdy) check({"stall_in_ready_", s}, 32'(ir), 32'd0);
    prev_stall[k] = we && !rdy;
    prev_addr[k]  = addr;
    prev_data[k]  = data;
    exp_d = done_pend[k];
    done_pend[k] = 1'b0;
    if (dn || exp_d) begin
      check({"done_pulse_", s}, 32'(dn), 32'(exp_d));
      check({"busy_in_done_", s}, 32'(bz), 32'd0);
    end
    if (dn) done_cnt[k]++;
    if (we && rdy) begin
      have = 1'b0;
      if (k == 0) begin if (qa.size() > 0) begin it = qa.pop_front(); have = 1'b1; end end
      else        begin if (qb.size() > 0) begin it = qb.pop_front(); have = 1'b1; end end
      if (!have) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write_%s: addr %h data %h with empty scoreboard", s, addr, data);
      end else begin
        exp_addr = (k == 0) ? (BASE_A + it.idx) % (1 << AW_A) : (BASE_B + it.idx) % (1 << AW_B);
        check({"wr_addr_", s}, addr, exp_addr);
        check({"wr_data_", s}, data, it.data);
        check({"wr_err_", s}, 32'(e), 32'(it.errc != 0));
        check({"wr_err_count_", s}, 32'(ec), it.errc);
        if (it.last) done_pend[k] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, bus_a.mem_we, mem_ready, 32'(bus_a.mem_addr), bus_a.mem_wdata, err_a, errc_a,
             done_a, busy_a, bus_a.in_ready);
    mon_step(1, bus_b.mem_we, mem_ready, 32'(bus_b.mem_addr), bus_b.mem_wdata, err_b, errc_b,
             done_b, busy_b, bus_b.in_ready);
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, tot;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    mem_ready = 1'b1;

    // Single ADDI x1,x0,-1.
    do_start();
    send_beat(mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF), 1'b1, 1'b1,
              32'hFFF0_0093, st);
    end_program();
    check("addi_err_a", 32'(err_a), 32'd0);

    // Back-to-back SW, BEQ, SRAI with memory always ready.
    do_start();
    send_beat(mk(7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8), 1'b0, 1'b1, 32'h0020_A423, st);
    tot = st;
    send_beat(mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC), 1'b0, 1'b1,
              32'hFE00_0EE3, st);
    tot += st;
    send_beat(mk(7'h13, 3'd5, 7'h20, 5'd3, 5'd3, 5'd0, 32'd4), 1'b1, 1'b1, 32'h4041_D193, st);
    tot += st;
    check("b2b_stall_cycles", 32'(tot), 32'd0);
    end_program();

    // Range errors.
    do_start();
    send_beat(mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048), 1'b0, 1'b1, 32'h0000_0013, st);
    send_beat(mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3), 1'b1, 1'b1, 32'h0000_0013, st);
    end_program();
    check("range_err_a", 32'(err_a), 32'd1);
    check("range_err_count_a", 32'(errc_a), 32'd2);
    check("range_err_count_b", 32'(errc_b), 32'd2);

    // Backpressure: memory stalls the first write for three cycles.
    mem_ready = 1'b0;
    do_start();
    send_beat(mk(7'h33, 3'd0, 7'h00, 5'd5, 5'd6, 5'd7, 32'd0), 1'b0, 1'b0, 32'd0, st);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
      end
      send_beat(mk(7'h03, 3'd2, 7'h00, 5'd9, 5'd2, 5'd0, 32'hFFFF_F800), 1'b1, 1'b0, 32'd0, st);
    join
    check("bp_stall_cycles", 32'(st), 32'd3);
    end_program();

    // Reset mid-load with a rejected write pending.
    mem_ready = 1'b0;
    do_start();
    send_beat(mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096), 1'b0, 1'b1, 32'h0000_0013, st);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("no_done_after_reset_a", 32'(done_cnt[0]), 32'(exp_done));
    check("no_done_after_reset_b", 32'(done_cnt[1]), 32'(exp_done));
    @(posedge clk);
    #1;
    do_start();
    send_beat(mk(7'h13, 3'd0, 7'h00, 5'd2, 5'd2, 5'd0, 32'd5), 1'b1, 1'b0, 32'd0, st);
    end_program();
    check("post_reset_err_count_a", 32'(errc_a), 32'd0);

    // Randomized program with random memory backpressure and input gaps.
    rand_rdy = 1'b1;
    do_start();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(rand_beat(), (i == 299), 1'b0, 32'd0, st);
    end
    end_program();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 mem_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("scoreboard_empty_a", 32'(qa.size()), 32'd0);
    check("scoreboard_empty_b", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
